// File: rtl/mips_cache_data_assoc.sv
// N-way set-associative, write-back, write-allocate data cache for the MIPS data port.
// One 32-bit word per line; true-LRU replacement via per-set age counters.
module mips_cache_data_assoc #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] writedata,
  input  logic [3:0]  byte_en,
  output logic [31:0] readdata,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_ack
);

  localparam int unsigned SETS  = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 32 - INDEX_BITS;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned AGE_W = WAY_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t state_q, state_d;

  logic             valid_q [SETS][WAYS];
  logic             dirty_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [31:0]      data_q  [SETS][WAYS];
  logic [AGE_W-1:0] age_q   [SETS][WAYS];
  logic [WAY_W-1:0] victim_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  full_wr;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] victim_way;

  logic             hit_wr, alloc_wr, wb_done, fill_done, touch;
  logic [WAY_W-1:0] touch_way;
  logic [AGE_W-1:0] old_age;
  logic [AGE_W-1:0] new_age [WAYS];

  assign idx     = addr[INDEX_BITS-1:0];
  assign tag     = addr[31:INDEX_BITS];
  assign full_wr = write_en && (byte_en == 4'hF);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_word;
    for (int k = 0; k < 4; k++) begin
      if (lanes[k]) r[8*k +: 8] = new_word[8*k +: 8];
    end
    return r;
  endfunction

  // Tag lookup and victim choice: lowest invalid way, else the oldest way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[idx][w] == AGE_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim_way = inv_found ? inv_way : lru_way;
  end

  // Next-state and outputs.
  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    readdata      = '0;
    mem_addr      = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_writedata = '0;
    hit_wr        = 1'b0;
    alloc_wr      = 1'b0;
    wb_done       = 1'b0;
    fill_done     = 1'b0;
    touch         = 1'b0;
    touch_way     = '0;
    case (state_q)
      IDLE: begin
        if (read_en || write_en) begin
          if (hit) begin
            readdata  = data_q[idx][hit_way];
            hit_wr    = write_en;
            touch     = 1'b1;
            touch_way = hit_way;
          end else if (valid_q[idx][victim_way] && dirty_q[idx][victim_way]) begin
            stall   = 1'b1;
            state_d = WRITEBACK;
          end else if (full_wr) begin
            alloc_wr  = 1'b1;
            touch     = 1'b1;
            touch_way = victim_way;
          end else begin
            stall   = 1'b1;
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        stall         = 1'b1;
        mem_write     = 1'b1;
        mem_addr      = {tag_q[idx][victim_q], idx};
        mem_writedata = data_q[idx][victim_q];
        if (mem_ack) begin
          wb_done = 1'b1;
          state_d = full_wr ? IDLE : FILL;
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        mem_addr = addr;
        if (mem_ack) begin
          fill_done = 1'b1;
          touch     = 1'b1;
          touch_way = victim_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // LRU ages after touching touch_way: it becomes youngest, younger ways age by one.
  always_comb begin
    old_age = age_q[idx][touch_way];
    for (int w = 0; w < int'(WAYS); w++) begin
      new_age[w] = age_q[idx][w];
      if (WAY_W'(w) == touch_way) new_age[w] = '0;
      else if (age_q[idx][w] < old_age) new_age[w] = age_q[idx][w] + AGE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && (state_d != IDLE)) victim_q <= victim_way;
      if (hit_wr) begin
        data_q[idx][hit_way]  <= merge_bytes(data_q[idx][hit_way], writedata, byte_en);
        dirty_q[idx][hit_way] <= 1'b1;
      end
      if (alloc_wr) begin
        valid_q[idx][victim_way] <= 1'b1;
        dirty_q[idx][victim_way] <= 1'b1;
        tag_q[idx][victim_way]   <= tag;
        data_q[idx][victim_way]  <= writedata;
      end
      if (wb_done) valid_q[idx][victim_q] <= 1'b0;
      if (fill_done) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
        tag_q[idx][victim_q]   <= tag;
        data_q[idx][victim_q]  <= mem_readdata;
      end
      if (touch) begin
        for (int w = 0; w < int'(WAYS); w++) age_q[idx][w] <= new_age[w];
      end
    end
  end

endmodule

// File: tb/tb_mips_cache_data_assoc.sv
// Self-checking bench for mips_cache_data_assoc (WAYS=4, INDEX_BITS=3) with a 3-cycle memory.
module tb_mips_cache_data_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        read_en, write_en;
  logic [31:0] writedata;
  logic [3:0]  byte_en;
  logic [31:0] readdata;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_ack;

  int n_vec = 0;
  int n_err = 0;

  mips_cache_data_assoc #(.WAYS(4), .INDEX_BITS(3)) dut (
    .clk(clk), .rst(rst), .addr(addr), .read_en(read_en), .write_en(write_en),
    .writedata(writedata), .byte_en(byte_en), .readdata(readdata), .stall(stall),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory: default contents a+0x100, acks on the third cycle of a request.
  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} log_t;
  logic [31:0] mem_store [bit [31:0]];
  log_t        mem_log [$];
  int          mem_cnt = 0;
  int          n_mem_rd = 0;
  int          n_mem_wr = 0;

  function automatic logic [31:0] mem_fetch(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return a + 32'h100;
  endfunction

  initial begin
    mem_ack      = 1'b0;
    mem_readdata = '0;
  end

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end else if (mem_read || mem_write) begin
      mem_cnt++;
      if (mem_cnt == 3) begin
        mem_ack = 1'b1;
        if (mem_write) begin
          mem_store[mem_addr] = mem_writedata;
          mem_log.push_back('{1'b1, mem_addr, mem_writedata});
          n_mem_wr++;
        end else begin
          mem_readdata = mem_fetch(mem_addr);
          mem_log.push_back('{1'b0, mem_addr, mem_readdata});
          n_mem_rd++;
        end
      end
    end else begin
      mem_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) begin
      n_vec++;
      n_err++;
      $display("FAIL mem_excl: mem_read=%b mem_write=%b, required not both high", mem_read, mem_write);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; read_en = 1'b0; write_en = 1'b0; addr = '0; writedata = '0; byte_en = '0;
    @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_writedata, 0);
    chk("rst_readdata", readdata, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One CPU request, held until stall drops; returns data seen on the completing cycle.
  task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rdata, output logic stalled);
    int n;
    n = 0;
    @(negedge clk);
    addr = a; read_en = rd; write_en = wr; writedata = wd; byte_en = be;
    #1;
    while (stall && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL access_timeout: addr 0x%08h still stalled after %0d cycles", a, n);
    end
    rdata   = readdata;
    stalled = (n > 0);
    @(posedge clk);
    #1;
    read_en = 1'b0; write_en = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_stall;
  } vec_t;
  vec_t vecs [$];

  function automatic vec_t mk(input logic [31:0] a, input logic rd, input logic wr,
                              input logic [31:0] wd, input logic [3:0] be,
                              input logic [31:0] er, input logic es);
    vec_t v;
    v.a = a; v.rd = rd; v.wr = wr; v.wd = wd; v.be = be; v.exp_rd = er; v.exp_stall = es;
    return v;
  endfunction

  task automatic apply_vec(input int i);
    logic [31:0] got;
    logic        st;
    access(vecs[i].a, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].be, got, st);
    if (vecs[i].rd && !vecs[i].wr) chk($sformatf("vec%0d_data", i), got, vecs[i].exp_rd);
    chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
  endtask

  // Reference: per-set recency list (index 0 = most recent) with dirty flags.
  int          lcnt   [8];
  logic [28:0] ltag   [8][4];
  bit          ldirty [8][4];
  logic [31:0] truth  [bit [31:0]];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] truth_get(input logic [31:0] a);
    if (truth.exists(a)) return truth[a];
    return mem_fetch(a);
  endfunction

  task automatic model_access(input logic [31:0] a, input logic wr, input logic [3:0] be,
                              output bit es, output bit ewb, output bit efill);
    int          s;
    logic [28:0] t;
    int          p;
    bit          d;
    s = int'(a[2:0]);
    t = a[31:3];
    p = -1;
    for (int i = 0; i < lcnt[s]; i++) if (ltag[s][i] == t) p = i;
    if (p >= 0) begin
      d = ldirty[s][p] | wr;
      for (int i = p; i > 0; i--) begin
        ltag[s][i] = ltag[s][i-1]; ldirty[s][i] = ldirty[s][i-1];
      end
      es = 1'b0; ewb = 1'b0; efill = 1'b0;
    end else begin
      ewb   = (lcnt[s] == 4) && ldirty[s][3];
      efill = !(wr && be == 4'hF);
      es    = ewb || efill;
      d     = wr;
      if (lcnt[s] < 4) lcnt[s]++;
      for (int i = lcnt[s] - 1; i > 0; i--) begin
        ltag[s][i] = ltag[s][i-1]; ldirty[s][i] = ldirty[s][i-1];
      end
    end
    ltag[s][0]   = t;
    ldirty[s][0] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, exp_val, a, wd;
    logic        st, rd, wr;
    logic [3:0]  be;
    bit          es, ewb, efill;
    int          snap, n, op, pred_rd, pred_wr, base_rd, base_wr, t2_end;

    rst = 1'b1; addr = '0; read_en = 1'b0; write_en = 1'b0; writedata = '0; byte_en = '0;

    // Cold reads, warm reads, full writes, readback.
    for (int i = 0; i < 8; i++) vecs.push_back(mk(32'(i), 1, 0, 0, 4'h0, 32'h100 + 32'(i), 1));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(32'(i), 1, 0, 0, 4'h0, 32'h100 + 32'(i), 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(32'(i), 0, 1, 32'(i * i), 4'hF, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(32'(i), 1, 0, 0, 4'h0, 32'(i * i), 0));
    t2_end = vecs.size();
    // Same-set fill, hit pass, LRU eviction.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++)
        vecs.push_back(mk(32'(8 * i), 1, 0, 0, 4'h0, 32'h100 + 32'(8 * i), (p == 0)));
    vecs.push_back(mk(32, 1, 0, 0, 4'h0, 32'h120, 1));
    vecs.push_back(mk(0,  1, 0, 0, 4'h0, 32'h100, 1));
    vecs.push_back(mk(24, 1, 0, 0, 4'h0, 32'h118, 0));
    vecs.push_back(mk(8,  1, 0, 0, 4'h0, 32'h108, 1));

    do_reset();
    for (int i = 0; i < 16; i++) apply_vec(i);
    snap = n_mem_rd + n_mem_wr;
    for (int i = 16; i < t2_end; i++) apply_vec(i);
    chk("t2_mem_traffic", 32'(n_mem_rd + n_mem_wr - snap), 0);
    do_reset();
    for (int i = t2_end; i < vecs.size(); i++) apply_vec(i);

    // Dirty eviction ordering and data round trip through memory.
    do_reset();
    mem_log.delete();
    access(0, 0, 1, 32'hDEADBEEF, 4'hF, got, st);
    chk("t4_alloc_stall", 32'(st), 0);
    access(8, 1, 0, 0, 4'h0, got, st);
    access(16, 1, 0, 0, 4'h0, got, st);
    access(24, 1, 0, 0, 4'h0, got, st);
    access(32, 1, 0, 0, 4'h0, got, st);
    chk("t4_read32", got, 32'h120);
    access(0, 1, 0, 0, 4'h0, got, st);
    chk("t4_reread0", got, 32'hDEADBEEF);
    chk("t4_reread0_stall", 32'(st), 1);
    chk("t4_log_len", 32'(mem_log.size()), 6);
    if (mem_log.size() >= 5) begin
      chk("t4_wb_kind", 32'(mem_log[3].w), 1);
      chk("t4_wb_addr", mem_log[3].a, 0);
      chk("t4_wb_data", mem_log[3].d, 32'hDEADBEEF);
      chk("t4_fill_kind", 32'(mem_log[4].w), 0);
      chk("t4_fill_addr", mem_log[4].a, 32);
    end

    // Partial write miss fetches and merges; full write miss does not fetch.
    do_reset();
    access(5, 0, 1, 32'h11223344, 4'b0101, got, st);
    chk("t5_partial_stall", 32'(st), 1);
    access(5, 1, 0, 0, 4'h0, got, st);
    chk("t5_partial_data", got, 32'h00220144);
    snap = n_mem_rd;
    access(13, 0, 1, 32'hCAFEF00D, 4'hF, got, st);
    chk("t5_full_stall", 32'(st), 0);
    chk("t5_full_no_read", 32'(n_mem_rd - snap), 0);
    access(13, 1, 0, 0, 4'h0, got, st);
    chk("t5_full_data", got, 32'hCAFEF00D);

    // Reset in the middle of a fill.
    do_reset();
    access(1, 1, 0, 0, 4'h0, got, st);
    access(2, 1, 0, 0, 4'h0, got, st);
    @(negedge clk);
    addr = 3; read_en = 1'b1;
    n = 0;
    #1;
    while (!mem_read && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t6_fill_started", 32'(mem_read), 1);
    @(negedge clk);
    rst = 1'b1; read_en = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_mem_read_drop", 32'(mem_read), 0);
    chk("t6_stall_drop", 32'(stall), 0);
    @(negedge clk);
    rst = 1'b0;
    access(1, 1, 0, 0, 4'h0, got, st);
    chk("t6_miss1_stall", 32'(st), 1);
    chk("t6_miss1_data", got, 32'h101);
    access(2, 1, 0, 0, 4'h0, got, st);
    chk("t6_miss2_stall", 32'(st), 1);

    // Randomized traffic against the recency-list reference.
    do_reset();
    truth.delete();
    for (int s = 0; s < 8; s++) lcnt[s] = 0;
    pred_rd = 0; pred_wr = 0;
    base_rd = n_mem_rd; base_wr = n_mem_wr;
    for (int i = 0; i < 300; i++) begin
      a  = 32'($urandom_range(0, 47));
      op = int'($urandom_range(0, 11));
      rd = (op < 5) || (op == 9);
      wr = (op >= 5) && (op <= 9);
      be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      wd = $urandom;
      if (!rd && !wr) begin
        access(a, 0, 0, wd, be, got, st);
        chk("rand_idle_stall", 32'(st), 0);
      end else begin
        model_access(a, wr, be, es, ewb, efill);
        pred_rd += int'(efill);
        pred_wr += int'(ewb);
        exp_val = truth_get(a);
        access(a, rd, wr, wd, be, got, st);
        chk($sformatf("rand%0d_stall", i), 32'(st), 32'(es));
        if (rd && !wr) chk($sformatf("rand%0d_data", i), got, exp_val);
        if (wr) truth[a] = merge(exp_val, wd, be);
      end
    end
    chk("rand_mem_reads", 32'(n_mem_rd - base_rd), 32'(pred_rd));
    chk("rand_mem_writes", 32'(n_mem_wr - base_wr), 32'(pred_wr));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
